// File: rtl/branch_fb_sched_pkg.sv
// Shared branch-feedback types and helpers for the resolution units and the
// feedback scheduler.
package core;

    localparam int TAG_W = 6;

    typedef logic                 bool_t;
    typedef logic [TAG_W-1:0]     branch_fb_tag_t;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } branch_pred_fb_t;

    typedef struct packed {
        branch_pred_fb_t fb;
        branch_fb_tag_t  tag;
        bool_t           kill;
    } fb_sched_entry_t;

    // Wrap-around age compare: a is older than b when (a - b) is negative mod 2^TAG_W.
    function automatic bool_t tag_older(input branch_fb_tag_t a, input branch_fb_tag_t b);
        branch_fb_tag_t diff;
        diff = a - b;
        return diff[TAG_W-1];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/branch_fb_sched_if.sv
// Bundle between the branch resolution sources, the feedback scheduler and
// the predictor feedback port.
interface branch_fb_sched_if #(
    parameter int src_cnt = 2,
    parameter int tag_w   = core::TAG_W
);
    logic [src_cnt-1:0]                   src_valid;
    core::branch_pred_fb_t [src_cnt-1:0]  src_fb;
    logic [src_cnt-1:0][tag_w-1:0]        src_tag;
    logic [src_cnt-1:0]                   src_ready;
    logic                                 flush;
    logic [tag_w-1:0]                     flush_tag;
    logic                                 stall;
    core::branch_pred_fb_t                fb;
    logic                                 pred_en;
    logic [15:0]                          emit_cnt;
    logic [15:0]                          drop_cnt;

    modport master (
        output src_valid, src_fb, src_tag, flush, flush_tag, stall,
        input  src_ready, fb, pred_en, emit_cnt, drop_cnt
    );

    modport slave (
        input  src_valid, src_fb, src_tag, flush, flush_tag, stall,
        output src_ready, fb, pred_en, emit_cnt, drop_cnt
    );
endinterface

// File: rtl/branch_fb_sched_arb.sv
// Combinational oldest-first picker over (valid, tag) pairs; ties go to the
// lowest index.
module fb_age_arb
    import core::*;
#(
    parameter int src_cnt = 2,
    parameter int tag_w   = TAG_W,
    localparam int IDX_W  = (src_cnt > 1) ? $clog2(src_cnt) : 1
) (
    input  logic [src_cnt-1:0]            valid,
    input  logic [src_cnt-1:0][tag_w-1:0] tag,
    output logic [src_cnt-1:0]            grant,
    output logic [IDX_W-1:0]              win_idx,
    output logic                          win_valid
);

    branch_fb_tag_t best_tag;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        best_tag  = '0;
        // Strictly-older replacement keeps the lower index on equal tags.
        for (int i = 0; i < src_cnt; i++) begin
            if (valid[i] && (!win_valid || tag_older(tag[i], best_tag))) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
                best_tag  = tag[i];
            end
        end
    end

    for (genvar gi = 0; gi < src_cnt; gi++) begin : g_grant
        assign grant[gi] = win_valid && (win_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/branch_fb_sched.sv
// Serialises resolved-branch feedback from several sources into the predictor's
// single feedback port, oldest first, discarding wrong-path entries on flush.
module branch_fb_sched
    import core::*;
#(
    parameter int src_cnt    = 2,
    parameter int fifo_depth = 4,
    parameter int tag_w      = TAG_W
) (
    input logic              clk,
    input logic              rst,
    branch_fb_sched_if.slave bus
);

    localparam int PTR_W = $clog2(fifo_depth);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (src_cnt > 1) ? $clog2(src_cnt) : 1;

    fb_sched_entry_t    slot_q [fifo_depth];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [15:0]        emit_cnt_reg;
    logic [15:0]        drop_cnt_reg;

    logic [src_cnt-1:0] grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    branch_fb_tag_t     win_tag;
    branch_pred_fb_t    win_fb;
    fb_sched_entry_t    head_entry;
    logic               pop;
    logic               pop_emit;
    logic               pop_drop;
    logic               space_ok;
    logic               accept;
    logic               drop_in;
    logic               push;
    logic [1:0]         drop_inc;

    fb_age_arb #(
        .src_cnt (src_cnt),
        .tag_w   (tag_w)
    ) u_arb (
        .valid     (bus.src_valid),
        .tag       (bus.src_tag),
        .grant     (grant),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    always_comb begin
        head_entry = slot_q[head_reg];
        pop        = (count_reg != '0) && !bus.stall;
        pop_emit   = pop && !head_entry.kill;
        pop_drop   = pop && head_entry.kill;
        // A full queue still accepts when the head leaves this cycle.
        space_ok   = (count_reg != CNT_W'(fifo_depth)) || pop;
        accept     = rst && win_valid && space_ok;
        win_tag    = bus.src_tag[win_idx];
        win_fb     = bus.src_fb[win_idx];
        drop_in    = accept && bus.flush && tag_older(bus.flush_tag, win_tag);
        push       = accept && !drop_in;
        drop_inc   = {1'b0, drop_in} + {1'b0, pop_drop};
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_comb begin
        bus.fb = '0;
        if (pop_emit) begin
            bus.fb       = head_entry.fb;
            bus.fb.valid = 1'b1;
        end
    end

    assign bus.src_ready = accept ? grant : '0;
    assign bus.pred_en   = rst && !bus.stall;
    assign bus.emit_cnt  = emit_cnt_reg;
    assign bus.drop_cnt  = drop_cnt_reg;

    // Killed entries stay in place and drain through the normal pop path.
    for (genvar gi = 0; gi < fifo_depth; gi++) begin : g_slot
        fb_sched_entry_t slot_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                slot_reg <= '0;
            end else if (push && (tail_reg == PTR_W'(gi))) begin
                slot_reg <= '{fb: win_fb, tag: win_tag, kill: 1'b0};
            end else if (bus.flush && tag_older(bus.flush_tag, slot_reg.tag)) begin
                slot_reg.kill <= 1'b1;
            end
        end

        assign slot_q[gi] = slot_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            emit_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            count_reg    <= count_next;
            emit_cnt_reg <= sat_add16(emit_cnt_reg, {1'b0, pop_emit});
            drop_cnt_reg <= sat_add16(drop_cnt_reg, drop_inc);
        end
    end

endmodule

// File: tb/tb_branch_fb_sched.sv
// Bench for branch_fb_sched: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_fb_sched;
    import core::*;

    localparam int SRC   = 2;
    localparam int DEPTH = 4;
    localparam int TW    = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_fb_sched_if #(.src_cnt(SRC), .tag_w(TW)) bus ();

    branch_fb_sched #(
        .src_cnt    (SRC),
        .fifo_depth (DEPTH),
        .tag_w      (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        branch_pred_fb_t fb;
        logic [5:0]      tag;
        bit              kill;
    } m_ent_t;

    m_ent_t mq[$];
    int     m_emit = 0;
    int     m_drop = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic branch_pred_fb_t mk_fb(input int src, input logic [5:0] tag, input bit v);
        branch_pred_fb_t f;
        f.valid  = v;
        f.taken  = tag[0];
        f.pc     = 32'h4000_0000 + 32'(src * 4096) + 32'(int'(tag) * 4);
        f.target = f.pc ^ 32'h00FF_0000;
        return f;
    endfunction

    // a older than b: distance from b to a, taken mod 64, lies in the upper half.
    function automatic bit m_older(input logic [5:0] a, input logic [5:0] b);
        int d;
        d = (int'(a) - int'(b) + 64) % 64;
        return d >= 32;
    endfunction

    // Source i wins if no other valid source is older, nor equal with a lower index.
    function automatic int m_winner();
        for (int i = 0; i < SRC; i++) begin
            if (bus.src_valid[i]) begin
                bit best = 1'b1;
                for (int j = 0; j < SRC; j++) begin
                    if (j != i && bus.src_valid[j]) begin
                        if (m_older(bus.src_tag[j], bus.src_tag[i])) best = 1'b0;
                        if (bus.src_tag[j] == bus.src_tag[i] && j < i) best = 1'b0;
                    end
                end
                if (best) return i;
            end
        end
        return -1;
    endfunction

    // Per-cycle compare against the model, then advance the model across the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mq.delete();
                m_emit = 0;
                m_drop = 0;
            end else begin
                int              w;
                bit              pop;
                branch_pred_fb_t exp_fb;
                logic [SRC-1:0]  exp_rdy;
                m_ent_t          ent;
                w       = m_winner();
                pop     = (mq.size() > 0) && !bus.stall;
                exp_fb  = '0;
                if (pop && !mq[0].kill) begin
                    exp_fb       = mq[0].fb;
                    exp_fb.valid = 1'b1;
                end
                exp_rdy = '0;
                if (w >= 0 && (mq.size() < DEPTH || pop)) exp_rdy[w] = 1'b1;
                chk("cyc_fb", bus.fb, exp_fb);
                chk("cyc_ready", bus.src_ready, exp_rdy);
                chk("cyc_pred_en", bus.pred_en, !bus.stall);
                chk("cyc_emit_cnt", bus.emit_cnt, (m_emit > 65535) ? 65535 : m_emit);
                chk("cyc_drop_cnt", bus.drop_cnt, (m_drop > 65535) ? 65535 : m_drop);
                if (pop) begin
                    if (mq[0].kill) m_drop++;
                    else m_emit++;
                    void'(mq.pop_front());
                end
                if (bus.flush) begin
                    foreach (mq[k]) if (m_older(bus.flush_tag, mq[k].tag)) mq[k].kill = 1'b1;
                end
                if (exp_rdy != '0) begin
                    if (bus.flush && m_older(bus.flush_tag, bus.src_tag[w])) begin
                        m_drop++;
                    end else begin
                        ent.fb   = bus.src_fb[w];
                        ent.tag  = bus.src_tag[w];
                        ent.kill = 1'b0;
                        mq.push_back(ent);
                    end
                end
            end
        end
    end

    task automatic set_src(input int i, input bit v, input logic [5:0] t);
        bus.src_valid[i] = v;
        bus.src_tag[i]   = t;
        bus.src_fb[i]    = mk_fb(i, t, 1'($urandom_range(0, 1)));
    endtask

    task automatic idle();
        for (int i = 0; i < SRC; i++) set_src(i, 1'b0, 6'd0);
        bus.flush     = 1'b0;
        bus.flush_tag = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [SRC-1:0] rdy;
        logic [5:0]     tg [SRC];
        logic [5:0]     nt;
        logic [5:0]     base;
        int             acc;

        idle();
        bus.stall = 1'b0;
        set_src(0, 1'b1, 6'd5);
        set_src(1, 1'b1, 6'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.src_ready, 0);
        chk("rst_fb", bus.fb, 0);
        chk("rst_pred_en", bus.pred_en, 0);
        chk("rst_emit", bus.emit_cnt, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        idle();
        rst = 1'b1;
        cyc();
        chk("idle_pred_en", bus.pred_en, 1);
        chk("idle_fb_valid", bus.fb.valid, 0);

        // Older tag on src1 goes first.
        set_src(0, 1'b1, 6'd5);
        set_src(1, 1'b1, 6'd3);
        #1;
        chk("arb_first", bus.src_ready, 2'b10);
        cyc();
        set_src(1, 1'b0, 6'd3);
        #1;
        chk("arb_second", bus.src_ready, 2'b01);
        chk("emit_src1_pc", bus.fb.pc, 32'h4000_100C);
        chk("emit_src1_valid", bus.fb.valid, 1);
        cyc();
        set_src(0, 1'b0, 6'd5);
        #1;
        chk("emit_src0_pc", bus.fb.pc, 32'h4000_0014);
        cyc();
        chk("emit_cnt_two", bus.emit_cnt, 2);
        chk("emit_done_valid", bus.fb.valid, 0);

        // Tag wrap and tie-break.
        set_src(0, 1'b1, 6'd62);
        set_src(1, 1'b1, 6'd1);
        #1;
        chk("wrap_ready", bus.src_ready, 2'b01);
        cyc();
        set_src(0, 1'b0, 6'd62);
        #1;
        chk("wrap_second", bus.src_ready, 2'b10);
        cyc();
        set_src(0, 1'b1, 6'd7);
        set_src(1, 1'b1, 6'd7);
        #1;
        chk("tie_ready", bus.src_ready, 2'b01);
        cyc();
        set_src(0, 1'b0, 6'd7);
        cyc();
        idle();
        repeat (4) cyc();

        // Stall with both sources streaming, then release.
        bus.stall = 1'b1;
        tg[0] = 6'd8;
        tg[1] = 6'd9;
        nt    = 6'd10;
        acc   = 0;
        for (int c = 0; c < 6; c++) begin
            set_src(0, 1'b1, tg[0]);
            set_src(1, 1'b1, tg[1]);
            #1;
            rdy = bus.src_ready;
            if (c >= 4) chk("full_ready", rdy, 0);
            cyc();
            for (int i = 0; i < SRC; i++) if (rdy[i]) begin acc++; tg[i] = nt; nt++; end
        end
        chk("stall_accepts", acc, 4);
        bus.stall = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            set_src(0, 1'b1, tg[0]);
            set_src(1, 1'b1, tg[1]);
            #1;
            rdy = bus.src_ready;
            cyc();
            for (int i = 0; i < SRC; i++) if (rdy[i]) begin acc++; tg[i] = nt; nt++; end
        end
        chk("steady_accepts", acc, 8);
        idle();
        repeat (6) cyc();

        // Flush scenario from a fresh reset.
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        bus.stall = 1'b1;
        for (int t = 10; t < 14; t++) begin
            set_src(0, 1'b1, 6'(t));
            cyc();
        end
        set_src(0, 1'b1, 6'd14);
        bus.stall     = 1'b0;
        bus.flush     = 1'b1;
        bus.flush_tag = 6'd11;
        #1;
        chk("flush_ready", bus.src_ready, 2'b01);
        chk("flush_head_pc", bus.fb.pc, 32'h4000_0028);
        chk("flush_head_valid", bus.fb.valid, 1);
        cyc();
        idle();
        #1;
        chk("flush_keep_pc", bus.fb.pc, 32'h4000_002C);
        chk("flush_keep_valid", bus.fb.valid, 1);
        chk("flush_drop_in", bus.drop_cnt, 1);
        cyc();
        chk("kill12_valid", bus.fb.valid, 0);
        cyc();
        chk("kill13_valid", bus.fb.valid, 0);
        chk("kill13_drop", bus.drop_cnt, 2);
        cyc();
        chk("flush_final_drop", bus.drop_cnt, 3);
        chk("flush_final_emit", bus.emit_cnt, 2);
        chk("flush_final_valid", bus.fb.valid, 0);

        // Reset while stalled with a queue and a flush in flight.
        bus.stall = 1'b1;
        for (int t = 20; t < 23; t++) begin
            set_src(0, 1'b1, 6'(t));
            cyc();
        end
        idle();
        bus.flush     = 1'b1;
        bus.flush_tag = 6'd20;
        #1;
        rst = 1'b0;
        #1;
        chk("rstmid_fb", bus.fb, 0);
        chk("rstmid_ready", bus.src_ready, 0);
        chk("rstmid_pred_en", bus.pred_en, 0);
        chk("rstmid_drop", bus.drop_cnt, 0);
        cyc();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        rst       = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("post_rst_valid", bus.fb.valid, 0);
            cyc();
        end

        // Randomized traffic with wrapping tags, stalls and flushes.
        base  = 6'd30;
        tg[0] = base;
        tg[1] = base + 6'd1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) base = base + 6'd1;
            bus.stall     = ($urandom_range(0, 3) == 0);
            bus.flush     = ($urandom_range(0, 7) == 0);
            bus.flush_tag = base + 6'($urandom_range(0, 7));
            for (int i = 0; i < SRC; i++) set_src(i, ($urandom_range(0, 9) < 7), tg[i]);
            #1;
            rdy = bus.src_ready;
            cyc();
            for (int i = 0; i < SRC; i++) if (rdy[i]) tg[i] = base + 6'($urandom_range(0, 7));
        end
        idle();
        bus.stall = 1'b0;
        repeat (8) cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/branch_fb_sched.md
Name: branch_fb_sched

Overview:
- Collects resolved-branch feedback from `src_cnt` branch resolution sources and serialises it to the branch predictor's single feedback port.
- Emits at most one feedback per cycle, oldest first, so global-history shifts occur in program order.
- Buffers feedback in a small FIFO and discards wrong-path feedback on flush.
- Sits between the execute-stage resolution units and `branch_pred`, and drives its `fb` and `en` inputs.

Parameters:
- src_cnt, 2, number of feedback sources
- fifo_depth, 4, feedback queue entries; power of two, >= 2
- tag_w, 6, width of the program-order age tag (wrap-around)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- src_valid  in  [src_cnt]  source i presents feedback; must not depend on src_ready
- src_fb  in  [src_cnt] x core::branch_pred_fb_t  feedback payload; the `.valid` field is ignored
- src_tag  in  [src_cnt] x tag_w  age tag of the source's branch
- src_ready  out  [src_cnt]  feedback from source i is accepted this cycle
- flush  in  1  kill all feedback younger than `flush_tag`
- flush_tag  in  tag_w  tag of the mispredicted branch; that branch itself survives
- stall  in  1  predictor must not consume feedback this cycle
- fb  out  core::branch_pred_fb_t  feedback to the predictor
- pred_en  out  1  predictor enable
- emit_cnt  out  16  saturating count of emitted feedbacks
- drop_cnt  out  16  saturating count of discarded feedbacks

Behaviour:
- Reset (rst=0, async):
  - FIFO empty, all kill bits clear, counters 0.
  - `fb` = all zero, `pred_en` = 0, `src_ready` = 0.
- Age compare: a is older than b iff signed(a - b) mod 2^tag_w < 0. Live tags never span more than 2^(tag_w-1).
- Arbitration (combinational):
  - Winner = oldest valid source.
  - Equal tags: lowest index wins.
  - Exactly one `src_ready` bit may be high: the winner's, and only if count < fifo_depth, or count == fifo_depth with a pop this cycle.
- Enqueue:
  - On winner valid & ready, push {fb payload, tag, kill=0} at the tail.
  - If `flush` is high the same cycle and the incoming tag is younger than `flush_tag`, the source is still accepted (ready high) but nothing is pushed. `drop_cnt` += 1.
- Pop:
  - Head present and stall=0: head pops.
  - Head kill=0: `fb` = head payload with `.valid`=1, `emit_cnt` += 1.
  - Head kill=1: `fb.valid`=0, `drop_cnt` += 1.
  - Stall=1: nothing pops and `fb.valid`=0.
- Output timing:
  - `fb` is driven from the registered head; there is no bypass. Feedback enqueued in cycle N is visible at the earliest in cycle N+1.
  - `pred_en` = !stall whenever rst is released.
  - `fb.valid`=0 while the FIFO is empty.
- Flush:
  - Registered. At the next edge, every stored entry whose tag is younger than `flush_tag` gets kill=1.
  - The head emitted in the flush cycle is still emitted.
  - Entries are not compacted; killed entries drain one per cycle through the normal pop path, subject to stall.
- Simultaneous events:
  - Push and pop in the same cycle when full is legal; count is unchanged.
  - Incoming drop plus killed-head pop in one cycle: `drop_cnt` += 2.
- Pointers: `clog2(fifo_depth)`-bit head and tail pointers that wrap, plus a count of `clog2(fifo_depth)+1` bits.
- Counters saturate at 16'hFFFF and never wrap.
- Reset mid-operation: the queue is lost, with no partial emission. An in-flight stall or flush is ignored.

Decomposition:
- Package `core`:
  - `branch_fb_tag_t` (tag_w bits)
  - `fb_sched_entry_t` {`core::branch_pred_fb_t` fb; `branch_fb_tag_t` tag; `bool_t` kill}
  - function `tag_older(a,b)`, shared with the resolution units.
- Sub-module `fb_age_arb`: combinational oldest-first picker over `src_cnt` (valid, tag) pairs. Outputs a one-hot grant and the winner index.
- FIFO storage, flush, and counters stay in `branch_fb_sched`.

Test Plan:
- Reset then idle → `fb.valid`=0, `pred_en`=0 during reset and 1 after, `src_ready`=0, counters 0.
- src0 tag 5 and src1 tag 3 valid together, stall=0 → src1 accepted first, src0 next cycle. `fb` emits pc(src1) at cycle 1 and pc(src0) at cycle 2. `emit_cnt`=2.
- Tag wrap: src0 tag 62, src1 tag 1 (tag_w=6) → src0 treated as older and accepted first. Equal tags 7/7 → src0 wins.
- Stall held 6 cycles with both sources streaming → exactly 4 entries accepted, `src_ready`=0 when full. Release stall → one pop and one push per cycle, ordering preserved.
- Queue tags 10, 11, 12, 13; `flush_tag`=11 while head 10 is emitting:
  - 10 and 11 are emitted.
  - 12 and 13 drain over 2 cycles with `fb.valid`=0.
  - `drop_cnt`=2.
  - An incoming tag 14 in the flush cycle gets ready=1 but is not stored; `drop_cnt`=3.
- Assert rst low with 3 entries queued and stall=1 → immediately empty, `fb.valid`=0. After release, nothing from the old queue is emitted.
